// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: write-back arbiter and register scoreboard for the RV32I
// register file. It grants one ALU/LSU result per cycle to the single write
// port and tracks pending destination registers so that issue stalls on
// RAW/WAW hazards.
// Optional feature macro: WB_RR_EN selects round-robin ALU/LSU arbitration.
// When it is undefined, the LSU has fixed priority over the ALU.
module regfile_wb_sched #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     iss_rs1,
  input  logic [AW-1:0]     iss_rs2,
  input  logic              iss_wr,
  output logic              iss_ready,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [AW-1:0]     lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              RegWEn,
  output logic [AW-1:0]     rsw,
  output logic [DATA_W-1:0] data_in,
  output logic [AW:0]       busy_cnt,
  output logic              wb_orphan
);

  localparam int unsigned CW = AW + 1;

  logic [NREGS-1:0]  busy_q, busy_d;
  logic [CW-1:0]     busy_cnt_q, busy_cnt_d;
  logic              regwen_q, regwen_d;
  logic [AW-1:0]     rsw_q, rsw_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic              wb_orphan_q, wb_orphan_d;

  logic              hz;
  logic              iss_fire;
  logic              alu_gnt, lsu_gnt;
  logic              wb_fire;
  logic [AW-1:0]     wb_rd;
  logic [DATA_W-1:0] wb_data;

  // Hazard check against the registered scoreboard; no write-back bypass.
  always_comb begin
    hz = busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_wr & busy_q[iss_rd]);
  end

  assign iss_ready = ~hz;
  assign iss_fire  = iss_valid & ~hz;

`ifdef WB_RR_EN
  logic favour_alu_q, favour_alu_d;

  // Round-robin grant: the source that was not granted last is favoured next.
  always_comb begin
    lsu_gnt      = lsu_valid & (~alu_valid | ~favour_alu_q);
    alu_gnt      = alu_valid & (~lsu_valid | favour_alu_q);
    favour_alu_d = favour_alu_q;
    if (lsu_gnt) begin
      favour_alu_d = 1'b1;
    end else if (alu_gnt) begin
      favour_alu_d = 1'b0;
    end
  end

  // Arbitration pointer; reset favours the LSU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      favour_alu_q <= 1'b0;
    end else begin
      favour_alu_q <= favour_alu_d;
    end
  end
`else
  // Fixed-priority grant: the LSU always wins.
  always_comb begin
    lsu_gnt = lsu_valid;
    alu_gnt = alu_valid & ~lsu_valid;
  end
`endif

  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  // Write-back mux, scoreboard update, orphan detection and popcount.
  always_comb begin
    wb_fire     = alu_gnt | lsu_gnt;
    wb_rd       = lsu_gnt ? lsu_rd : alu_rd;
    wb_data     = lsu_gnt ? lsu_data : alu_data;
    busy_d      = busy_q;
    regwen_d    = 1'b0;
    rsw_d       = rsw_q;
    data_in_d   = data_in_q;
    wb_orphan_d = wb_orphan_q;
    busy_cnt_d  = '0;
    if (wb_fire) begin
      regwen_d      = (wb_rd != '0);
      rsw_d         = wb_rd;
      data_in_d     = wb_data;
      busy_d[wb_rd] = 1'b0;
      if ((wb_rd != '0) && !busy_q[wb_rd]) begin
        wb_orphan_d = 1'b1;
      end
    end
    // A new issue wins over a clear of the same register.
    if (iss_fire && iss_wr && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
    end
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      busy_cnt_q  <= '0;
      regwen_q    <= 1'b0;
      rsw_q       <= '0;
      data_in_q   <= '0;
      wb_orphan_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      busy_cnt_q  <= busy_cnt_d;
      regwen_q    <= regwen_d;
      rsw_q       <= rsw_d;
      data_in_q   <= data_in_d;
      wb_orphan_q <= wb_orphan_d;
    end
  end

  assign RegWEn    = regwen_q;
  assign rsw       = rsw_q;
  assign data_in   = data_in_q;
  assign busy_cnt  = busy_cnt_q;
  assign wb_orphan = wb_orphan_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed testbench for regfile_wb_sched (default build or WB_RR_EN build).
module tb_regfile_wb_sched;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AW     = 5;

  logic              clk;
  logic              rst;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd, iss_rs1, iss_rs2;
  logic              iss_wr;
  logic              iss_ready;
  logic              alu_valid, lsu_valid;
  logic [AW-1:0]     alu_rd, lsu_rd;
  logic [DATA_W-1:0] alu_data, lsu_data;
  logic              alu_ready, lsu_ready;
  logic              RegWEn;
  logic [AW-1:0]     rsw;
  logic [DATA_W-1:0] data_in;
  logic [AW:0]       busy_cnt;
  logic              wb_orphan;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_sched dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_wr(iss_wr), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .RegWEn(RegWEn), .rsw(rsw), .data_in(data_in),
    .busy_cnt(busy_cnt), .wb_orphan(wb_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = rd; iss_rs1 = '0; iss_rs2 = '0;
    #1;
    check("issue_ready", 32'(iss_ready), 32'd1);
    step();
    idle();
  endtask

  // Probe the scoreboard bit of r through iss_ready (no issue fired).
  task automatic probe(input string tag, input logic [AW-1:0] r, input logic exp_busy);
    iss_valid = 1'b0; iss_wr = 1'b0; iss_rs1 = r;
    #1;
    check(tag, 32'(iss_ready), 32'(!exp_busy));
    iss_rs1 = '0;
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  logic [AW-1:0] alu_q [2];
  logic [AW-1:0] lsu_q [2];
  logic          exp_l [4];

  initial begin
    int ai, li;
    logic [AW-1:0] grd;
    idle();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    step();

    // Reset values
    check("rst_regwen", 32'(RegWEn), 32'd0);
    check("rst_rsw", 32'(rsw), 32'd0);
    check("rst_data", data_in, 32'd0);
    check("rst_busy_cnt", 32'(busy_cnt), 32'd0);
    check("rst_orphan", 32'(wb_orphan), 32'd0);

    // RAW on rd=5, then ALU write-back clears it with a one-cycle lag
    issue(5'd5);
    check("busy_cnt_1", 32'(busy_cnt), 32'd1);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd6; iss_rs1 = 5'd5;
    #1;
    check("raw_stall", 32'(iss_ready), 32'd0);
    iss_rs1 = '0; iss_rd = 5'd5;
    #1;
    check("waw_stall", 32'(iss_ready), 32'd0);
    idle();
    iss_rs1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check("alu_ready_5", 32'(alu_ready), 32'd1);
    check("lsu_ready_5", 32'(lsu_ready), 32'd0);
    check("no_bypass", 32'(iss_ready), 32'd0);
    step();
    alu_valid = 1'b0;
    #1;
    check("wb5_regwen", 32'(RegWEn), 32'd1);
    check("wb5_rsw", 32'(rsw), 32'd5);
    check("wb5_data", data_in, 32'hDEADBEEF);
    check("wb5_ready", 32'(iss_ready), 32'd1);
    check("wb5_busy_cnt", 32'(busy_cnt), 32'd0);
    idle();
    step();
    check("wb5_regwen_drop", 32'(RegWEn), 32'd0);

    // x0 destination: never busy, never written, never orphan
    issue(5'd0);
    check("x0_busy_cnt", 32'(busy_cnt), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    check("x0_alu_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    check("x0_regwen", 32'(RegWEn), 32'd0);
    check("x0_orphan", 32'(wb_orphan), 32'd0);
    check("x0_busy_cnt2", 32'(busy_cnt), 32'd0);

    // Simultaneous ALU rd=3 / LSU rd=4: LSU wins first (pointer favours LSU)
    issue(5'd3);
    issue(5'd4);
    check("arb_busy_cnt", 32'(busy_cnt), 32'd2);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA3;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hB4;
    #1;
    check("arb_lsu_first", 32'(lsu_ready), 32'd1);
    check("arb_alu_wait", 32'(alu_ready), 32'd0);
    step();
    lsu_valid = 1'b0;
    #1;
    check("arb_rsw_4", 32'(rsw), 32'd4);
    check("arb_data_4", data_in, 32'hB4);
    check("arb_alu_next", 32'(alu_ready), 32'd1);
    step();
    idle();
    check("arb_rsw_3", 32'(rsw), 32'd3);
    check("arb_data_3", data_in, 32'hA3);
    check("arb_busy_cnt0", 32'(busy_cnt), 32'd0);

    // Continuous dual requests for 4 cycles
    issue(5'd10); issue(5'd11); issue(5'd12); issue(5'd13);
    alu_q[0] = 5'd10; alu_q[1] = 5'd13;
    lsu_q[0] = 5'd11; lsu_q[1] = 5'd12;
`ifdef WB_RR_EN
    exp_l[0] = 1'b1; exp_l[1] = 1'b0; exp_l[2] = 1'b1; exp_l[3] = 1'b0;
`else
    exp_l[0] = 1'b1; exp_l[1] = 1'b1; exp_l[2] = 1'b0; exp_l[3] = 1'b0;
`endif
    ai = 0; li = 0;
    for (int c = 0; c < 4; c++) begin
      alu_valid = (ai < 2); alu_rd = alu_q[ai % 2]; alu_data = 32'hA000_0000 | 32'(alu_rd);
      lsu_valid = (li < 2); lsu_rd = lsu_q[li % 2]; lsu_data = 32'hB000_0000 | 32'(lsu_rd);
      #1;
      check($sformatf("dual_lsu_ready_%0d", c), 32'(lsu_ready), 32'(exp_l[c]));
      check($sformatf("dual_alu_ready_%0d", c), 32'(alu_ready), 32'(!exp_l[c]));
      if (exp_l[c]) begin grd = lsu_q[li]; li++; end
      else begin grd = alu_q[ai]; ai++; end
      step();
      check($sformatf("dual_rsw_%0d", c), 32'(rsw), 32'(grd));
      check($sformatf("dual_data_%0d", c), data_in,
            (exp_l[c] ? 32'hB000_0000 : 32'hA000_0000) | 32'(grd));
    end
    idle();
    check("dual_busy_cnt0", 32'(busy_cnt), 32'd0);
    check("dual_orphan", 32'(wb_orphan), 32'd0);

    // Orphan write-back to idle register 7
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777;
    #1;
    check("orph_ready", 32'(alu_ready), 32'd1);
    step();
    idle();
    check("orph_regwen", 32'(RegWEn), 32'd1);
    check("orph_rsw", 32'(rsw), 32'd7);
    check("orph_data", data_in, 32'h7777);
    check("orph_flag", 32'(wb_orphan), 32'd1);
    step(); step();
    check("orph_sticky", 32'(wb_orphan), 32'd1);
    check("orph_busy_cnt", 32'(busy_cnt), 32'd0);

    // Issue rd=9 on the same edge as LSU clears rd=2
    issue(5'd2);
    check("same_pre_cnt", 32'(busy_cnt), 32'd1);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd9;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h22;
    #1;
    check("same_iss_ready", 32'(iss_ready), 32'd1);
    check("same_lsu_ready", 32'(lsu_ready), 32'd1);
    step();
    idle();
    check("same_busy_cnt", 32'(busy_cnt), 32'd1);
    probe("same_busy9", 5'd9, 1'b1);
    probe("same_clear2", 5'd2, 1'b0);

    // Async reset mid-operation: busy[5] set and RegWEn high
    issue(5'd5);
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    step();
    idle();
    check("pre_rst_regwen", 32'(RegWEn), 32'd1);
    check("pre_rst_cnt", 32'(busy_cnt), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("arst_regwen", 32'(RegWEn), 32'd0);
    check("arst_rsw", 32'(rsw), 32'd0);
    check("arst_data", data_in, 32'd0);
    check("arst_busy_cnt", 32'(busy_cnt), 32'd0);
    check("arst_orphan", 32'(wb_orphan), 32'd0);
    probe("arst_busy5", 5'd5, 1'b0);
    step();
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
